main_decoder: RTL and testbench

Registered instruction-decode slice for the single-cycle MIPS datapath. It turns a 32-bit instruction into the main control word, sign-extends the 16-bit immediate, and computes the branch target (PC+4 + SignImm<<2) and jump target. All results are registered once, with one cycle of latency, so they can feed either the single-cycle core or a decode/execute boundary.

---
 rtl/main_decoder.sv | 131 +++++++++++++
 tb/tb_main_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/main_decoder.sv
//------------------------------------------------------------------------------
// main_decoder: registered MIPS main-control decode, sign extension, and
// branch/jump target generation with one cycle of latency.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module main_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic        valid_out,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        branch,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        jump,
  output logic        illegal,
  output logic [31:0] sign_imm,
  output logic [31:0] branch_target,
  output logic        branch_carry,
  output logic [31:0] jump_target
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [5:0]  opcode;
  logic [8:0]  ctrl_d;
  logic        illegal_d;
  logic [31:0] sign_imm_d;
  logic [31:0] imm_shift;
  logic [31:0] sum_d;
  logic        carry_d;
  logic [31:0] jump_target_d;

  assign opcode = instr[31:26];

  // Control word: {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, alu_op, jump}
  always_comb begin
    ctrl_d    = 9'b0_0_0_0_0_0_00_0;
    illegal_d = 1'b0;
    case (opcode)
      OP_RTYPE: ctrl_d = 9'b1_1_0_0_0_0_10_0;
      OP_LW:    ctrl_d = 9'b1_0_1_0_0_1_00_0;
      OP_SW:    ctrl_d = 9'b0_0_1_0_1_0_00_0;
      OP_BEQ:   ctrl_d = 9'b0_0_0_1_0_0_01_0;
      OP_ADDI:  ctrl_d = 9'b1_0_1_0_0_0_00_0;
      OP_J:     ctrl_d = 9'b0_0_0_0_0_0_00_1;
      default:  illegal_d = 1'b1;
    endcase
  end

  assign sign_imm_d    = {{16{instr[15]}}, instr[15:0]};
  assign imm_shift     = {sign_imm_d[29:0], 2'b00};
  assign jump_target_d = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Branch adder: eight 4-bit lookahead groups, carry rippled between groups.
  logic [31:0] prop;
  logic [31:0] gen;
  logic [32:0] carry;

  assign prop     = pc_plus4 ^ imm_shift;
  assign gen      = pc_plus4 & imm_shift;
  assign carry[0] = 1'b0;

  generate
    for (genvar grp = 0; grp < 8; grp++) begin : g_cla
      logic [3:0] p;
      logic [3:0] g;
      logic       cin;
      assign p   = prop[grp*4 +: 4];
      assign g   = gen[grp*4 +: 4];
      assign cin = carry[grp*4];
      assign carry[grp*4+1] = g[0] | (p[0] & cin);
      assign carry[grp*4+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      assign carry[grp*4+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                            | (p[2] & p[1] & p[0] & cin);
      assign carry[grp*4+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                            | (p[3] & p[2] & p[1] & g[0])
                            | (p[3] & p[2] & p[1] & p[0] & cin);
    end
  endgenerate

  assign sum_d   = prop ^ carry[31:0];
  assign carry_d = carry[32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out     <= 1'b0;
      reg_write     <= 1'b0;
      reg_dst       <= 1'b0;
      alu_src       <= 1'b0;
      branch        <= 1'b0;
      mem_write     <= 1'b0;
      mem_to_reg    <= 1'b0;
      alu_op        <= 2'b00;
      jump          <= 1'b0;
      illegal       <= 1'b0;
      sign_imm      <= 32'h0;
      branch_target <= 32'h0;
      branch_carry  <= 1'b0;
      jump_target   <= 32'h0;
    end else if (valid_in) begin
      valid_out     <= 1'b1;
      {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, alu_op, jump} <= ctrl_d;
      illegal       <= illegal_d;
      sign_imm      <= sign_imm_d;
      branch_target <= sum_d;
      branch_carry  <= carry_d;
      jump_target   <= jump_target_d;
    end else begin
      // Idle cycle: drop every enable so nothing stale can fire; data holds.
      valid_out     <= 1'b0;
      {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, alu_op, jump} <= 9'b0;
      illegal       <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_main_decoder.sv
//------------------------------------------------------------------------------
// tb_main_decoder: scoreboard bench with directed, hand-computed vectors.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_main_decoder;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic        valid_out;
  logic        reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump;
  logic [1:0]  alu_op;
  logic        illegal;
  logic [31:0] sign_imm, branch_target, jump_target;
  logic        branch_carry;

  main_decoder dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .instr(instr), .pc_plus4(pc_plus4),
    .valid_out(valid_out), .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .branch(branch), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .jump(jump), .illegal(illegal), .sign_imm(sign_imm), .branch_target(branch_target),
    .branch_carry(branch_carry), .jump_target(jump_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [8:0]  ctrl;
    logic        chk_ill;
    logic        ill;
    logic [31:0] si;
    logic [31:0] bt;
    logic        c;
    logic [31:0] jt;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  logic [31:0] last_si, last_bt, last_jt;
  logic        last_c;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_now();
    return {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, alu_op, jump};
  endfunction

  // Monitor: one scoreboard entry per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("valid_out", {127'b0, valid_out}, {127'b0, e.vld});
        cmp("ctrl", {119'b0, ctrl_now()}, {119'b0, e.ctrl});
        if (e.chk_ill) cmp("illegal", {127'b0, illegal}, {127'b0, e.ill});
        cmp("sign_imm", {96'b0, sign_imm}, {96'b0, e.si});
        cmp("branch_target", {96'b0, branch_target}, {96'b0, e.bt});
        cmp("branch_carry", {127'b0, branch_carry}, {127'b0, e.c});
        cmp("jump_target", {96'b0, jump_target}, {96'b0, e.jt});
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [8:0] ctrl,
                       input logic ill, input logic [31:0] si, input logic [31:0] bt,
                       input logic c, input logic [31:0] jt);
    exp_t e;
    @(negedge clk);
    valid_in = 1'b1;
    instr    = ins;
    pc_plus4 = pc;
    e.vld = 1'b1; e.ctrl = ctrl; e.chk_ill = 1'b1; e.ill = ill;
    e.si = si; e.bt = bt; e.c = c; e.jt = jt;
    q.push_back(e);
    last_si = si; last_bt = bt; last_c = c; last_jt = jt;
  endtask

  task automatic idle();
    exp_t e;
    @(negedge clk);
    valid_in = 1'b0;
    instr    = 32'hFFFF_FFFF;
    pc_plus4 = 32'h1234_5678;
    e.vld = 1'b0; e.ctrl = 9'b0; e.chk_ill = 1'b0; e.ill = 1'b0;
    e.si = last_si; e.bt = last_bt; e.c = last_c; e.jt = last_jt;
    q.push_back(e);
  endtask

  function automatic logic [127:0] all_outs();
    return {20'b0, valid_out, ctrl_now(), illegal, sign_imm, branch_target, branch_carry, jump_target};
  endfunction

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    instr    = 32'h0;
    pc_plus4 = 32'h0;
    #12;
    cmp("reset_state", all_outs(), 128'h0);
    @(negedge clk);
    reset = 1'b0;

    //      instr         pc_plus4      ctrl          ill  sign_imm      br_target     c  jump_target
    issue(32'h00851020, 32'h00400004, 9'b110000100, 0, 32'h00001020, 32'h00404084, 0, 32'h02144080);
    issue(32'h8C880004, 32'h00400008, 9'b101001000, 0, 32'h00000004, 32'h00400018, 0, 32'h02200010);
    issue(32'hAC8A7FFF, 32'h00400004, 9'b001010000, 0, 32'h00007FFF, 32'h00420000, 0, 32'h0229FFFC);
    issue(32'h1085FFFF, 32'h00400004, 9'b000100010, 0, 32'hFFFFFFFF, 32'h00400000, 1, 32'h0217FFFC);
    issue(32'h20888000, 32'h00400004, 9'b101000000, 0, 32'hFFFF8000, 32'h003E0004, 1, 32'h02220000);
    issue(32'h10850004, 32'h00400004, 9'b000100010, 0, 32'h00000004, 32'h00400014, 0, 32'h02140010);
    issue(32'h20880001, 32'hFFFFFFFC, 9'b101000000, 0, 32'h00000001, 32'h00000000, 1, 32'hF2200004);
    issue(32'hFC000000, 32'h00400004, 9'b000000000, 1, 32'h00000000, 32'h00400004, 0, 32'h00000000);
    issue(32'h00000000, 32'h00000000, 9'b110000100, 0, 32'h00000000, 32'h00000000, 0, 32'h00000000);
    issue(32'h08000100, 32'h80000010, 9'b000000001, 0, 32'h00000100, 32'h80000410, 0, 32'h80000400);
    idle();

    // Reset between edges while a lw is registered.
    issue(32'h8C880004, 32'h00400008, 9'b101001000, 0, 32'h00000004, 32'h00400018, 0, 32'h02200010);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    cmp("reset_async", all_outs(), 128'h0);
    @(negedge clk);
    valid_in = 1'b0;
    reset    = 1'b0;
    last_si = 32'h0; last_bt = 32'h0; last_c = 1'b0; last_jt = 32'h0;

    issue(32'h08000100, 32'h80000010, 9'b000000001, 0, 32'h00000100, 32'h80000410, 0, 32'h80000400);
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
